// File: rtl/cpu_ctrl_pkg.sv
// Shared decode constants, ALU op encodings, FSM state type and the instruction
// classifier used by seq_control_fsm and imm_gen.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [5:0] F6_BASE = 6'b000000;
    localparam logic [5:0] F6_ALT  = 6'b010000;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010, ALU_SLL = 4'b0011,
        ALU_SRL  = 4'b0100, ALU_SRA = 4'b0101, ALU_SUB = 4'b0110, ALU_SLTU = 4'b0111,
        ALU_SLT  = 4'b1000, ALU_XOR = 4'b1001, ALU_EQ  = 4'b1010, ALU_NE  = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_e;

    typedef enum logic [1:0] {KIND_ALU, KIND_LOAD, KIND_STORE, KIND_BRANCH} kind_e;

    typedef struct packed {
        kind_e   kind;
        alu_op_e alu_op;
        logic    alu_src;
        logic    br_inv;   // branch condition is the complement of the ALU compare
        logic    ovf_ok;   // ADD/SUB/ADDI: signed overflow is meaningful
        logic    sys;
        logic    bad;
    } dec_t;

    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t decode_instr(input logic [31:0] ir);
        dec_t       d;
        logic [2:0] f3;
        f3 = ir[14:12];
        d  = '{kind: KIND_ALU, alu_op: ALU_ADD, alu_src: 1'b0, br_inv: 1'b0,
               ovf_ok: 1'b0, sys: 1'b0, bad: 1'b0};
        case (ir[6:0])
            OPC_R: begin
                d.alu_op = f3_to_alu(f3, ir[30]);
                if (ir[31:25] == F7_ALT) d.bad = !(f3 == F3_ADD || f3 == F3_SR);
                else                     d.bad = (ir[31:25] != F7_BASE);
                d.ovf_ok = (f3 == F3_ADD);
            end
            OPC_I: begin
                d.alu_src = 1'b1;
                d.alu_op  = f3_to_alu(f3, (f3 == F3_SR) && ir[30]);
                if (f3 == F3_SLL)     d.bad = (ir[31:26] != F6_BASE);
                else if (f3 == F3_SR) d.bad = !(ir[31:26] == F6_BASE || ir[31:26] == F6_ALT);
                d.ovf_ok = (f3 == F3_ADD);
            end
            OPC_LD: begin
                d.kind    = KIND_LOAD;
                d.alu_src = 1'b1;
                d.bad     = (f3 != F3_DW);
            end
            OPC_SD: begin
                d.kind    = KIND_STORE;
                d.alu_src = 1'b1;
                d.bad     = (f3 != F3_DW);
            end
            OPC_BR: begin
                d.kind   = KIND_BRANCH;
                d.br_inv = (f3 == F3_BGE) || (f3 == F3_BGEU);
                case (f3)
                    F3_BEQ:          d.alu_op = ALU_EQ;
                    F3_BNE:          d.alu_op = ALU_NE;
                    F3_BLT, F3_BGE:  d.alu_op = ALU_SLT;
                    F3_BLTU, F3_BGEU: d.alu_op = ALU_SLTU;
                    default:         d.bad = 1'b1;
                endcase
            end
            default: begin
                d.sys = (ir == WORD_ECALL) || (ir == WORD_EBREAK);
                d.bad = !d.sys;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for I, S and B formats (I is the default).
module imm_gen
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [12:0] imm_low;
    logic        unused_bits;

    always_comb begin
        case (instr[6:0])
            OPC_SD:  imm_low = {instr[31], instr[31:25], instr[11:7]};
            OPC_BR:  imm_low = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm_low = {instr[31], instr[31:20]};
        endcase
    end

    assign imm[12:0]   = imm_low;
    assign unused_bits = ^instr[19:12];

    genvar gi;
    generate
        for (gi = 13; gi < XLEN; gi++) begin : g_sext
            assign imm[gi] = imm_low[12];
        end
    endgenerate

endmodule

// File: rtl/seq_control_fsm.sv
// Multi-cycle control FSM for the sequential RV64 core.
// Define OVERFLOW_TRAP_EN to halt on signed overflow of ADD/SUB/ADDI (adds ovf_trap port).
module seq_control_fsm #(
    parameter int XLEN        = 64,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_overflow,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [XLEN-1:0]  imm,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_en,
    output logic             pc_src,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
`ifdef OVERFLOW_TRAP_EN
    ,
    output logic             ovf_trap
`endif
);
    import cpu_ctrl_pkg::*;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e            state_reg, state_next;
    logic [31:0]       ir_reg;
    dec_t              dec;
    logic [XLEN-1:0]   imm_dec;
    kind_e             kind_reg;
    logic              br_inv_reg;
    logic [4:0]        rs1_addr_reg, rs2_addr_reg, rd_addr_reg;
    logic [XLEN-1:0]   imm_reg;
    alu_op_e           alu_op_reg;
    logic              alu_src_reg, branch_reg, mem_to_reg_reg;
    logic [TW-1:0]     tmo_cnt_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              illegal_reg, bus_err_reg;
    logic              taken, tmo_hit, ovf_halt, retire_en;
    logic              unused_bits;

    assign dec     = decode_instr(ir_reg);
    assign taken   = alu_result[0] ^ br_inv_reg;
    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

`ifdef OVERFLOW_TRAP_EN
    logic ovf_ok_reg, ovf_trap_reg;
    assign ovf_halt    = ovf_ok_reg && alu_overflow;
    assign ovf_trap    = ovf_trap_reg;
    assign unused_bits = ^alu_result[XLEN-1:1];
`else
    assign ovf_halt    = 1'b0;
    assign unused_bits = ^{alu_result[XLEN-1:1], alu_overflow, dec.ovf_ok};
`endif

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (ir_reg),
        .imm   (imm_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:     if (instr_valid) state_next = DECODE;
            DECODE:    state_next = (dec.sys || dec.bad) ? HALT : EXECUTE;
            EXECUTE: begin
                if (kind_reg == KIND_BRANCH)                            state_next = FETCH;
                else if (kind_reg == KIND_LOAD || kind_reg == KIND_STORE) state_next = MEMORY;
                else if (ovf_halt)                                      state_next = HALT;
                else                                                    state_next = WRITEBACK;
            end
            // A ready that arrives on the last allowed cycle still completes the access.
            MEMORY: begin
                if (dmem_ready)   state_next = (kind_reg == KIND_LOAD) ? WRITEBACK : FETCH;
                else if (tmo_hit) state_next = HALT;
            end
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        retire_en = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH: imem_req = 1'b1;
                EXECUTE: begin
                    if (kind_reg == KIND_BRANCH) begin
                        pc_en     = 1'b1;
                        pc_src    = taken;
                        retire_en = 1'b1;
                    end
                end
                MEMORY: begin
                    mem_read  = (kind_reg == KIND_LOAD);
                    mem_write = (kind_reg == KIND_STORE);
                    if (dmem_ready && kind_reg == KIND_STORE) begin
                        pc_en     = 1'b1;
                        retire_en = 1'b1;
                    end
                end
                WRITEBACK: begin
                    reg_write = (rd_addr_reg != 5'd0);
                    pc_en     = 1'b1;
                    retire_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg         <= '0;
            kind_reg       <= KIND_ALU;
            br_inv_reg     <= 1'b0;
            rs1_addr_reg   <= '0;
            rs2_addr_reg   <= '0;
            rd_addr_reg    <= '0;
            imm_reg        <= '0;
            alu_op_reg     <= ALU_AND;
            alu_src_reg    <= 1'b0;
            branch_reg     <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            tmo_cnt_reg    <= '0;
            retired_reg    <= '0;
            illegal_reg    <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            if (state_reg == FETCH && instr_valid) ir_reg <= instr;
            if (state_reg == DECODE) begin
                kind_reg       <= dec.kind;
                br_inv_reg     <= dec.br_inv;
                rs1_addr_reg   <= ir_reg[19:15];
                rs2_addr_reg   <= ir_reg[24:20];
                rd_addr_reg    <= ir_reg[11:7];
                imm_reg        <= imm_dec;
                alu_op_reg     <= dec.alu_op;
                alu_src_reg    <= dec.alu_src;
                branch_reg     <= (dec.kind == KIND_BRANCH);
                mem_to_reg_reg <= (dec.kind == KIND_LOAD);
                if (dec.bad) illegal_reg <= 1'b1;
            end
            if (state_reg == EXECUTE)
                tmo_cnt_reg <= '0;
            else if (state_reg == MEMORY && !dmem_ready && !tmo_hit)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            if (state_reg == MEMORY && !dmem_ready && tmo_hit) bus_err_reg <= 1'b1;
            if (retire_en) retired_reg <= retired_reg + 1'b1;
        end
    end

`ifdef OVERFLOW_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_ok_reg   <= 1'b0;
            ovf_trap_reg <= 1'b0;
        end else begin
            if (state_reg == DECODE) ovf_ok_reg <= dec.ovf_ok && (dec.kind == KIND_ALU);
            if (state_reg == EXECUTE && ovf_halt) ovf_trap_reg <= 1'b1;
        end
    end
`endif

    assign rs1_addr   = rs1_addr_reg;
    assign rs2_addr   = rs2_addr_reg;
    assign rd_addr    = rd_addr_reg;
    assign imm        = imm_reg;
    assign alu_src    = alu_src_reg;
    assign alu_op     = alu_op_reg;
    assign branch     = branch_reg;
    assign mem_to_reg = mem_to_reg_reg;
    assign halted     = (state_reg == HALT);
    assign illegal    = illegal_reg;
    assign bus_err    = bus_err_reg;
    assign retired    = retired_reg;

endmodule

// File: doc/seq_control_fsm.md
Name: seq_control_fsm

Overview:
Multi-cycle control unit for the sequential RV64 core, sitting on the producer side of the execute-stage interface.
- Latches the fetched instruction, decodes it, and generates the immediate plus the alu_src, alu_op and branch controls that the execute stage consumes.
- Consumes the ALU result and overflow flag back from the execute stage to resolve branches.
- Sequences memory access and register writeback.
- Counts retired instructions and halts on ECALL, EBREAK, an illegal instruction or a data-bus timeout.

Parameters:
XLEN, 64, datapath and immediate width
MEM_TIMEOUT, 16, max cycles waiting for dmem_ready before bus error (≥1)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr  in  32  instruction word from imem
instr_valid  in  1  instr valid (FETCH handshake)
alu_result  in  XLEN  result from execute stage; bit0 used for branches
alu_overflow  in  1  overflow from execute stage
dmem_ready  in  1  data memory access complete
imem_req  out  1  fetch request
rs1_addr, rs2_addr, rd_addr  out  5 each  decoded register indices
imm  out  XLEN  sign-extended immediate
alu_src  out  1  1 = imm operand, 0 = rs2
alu_op  out  4  ALU operation code
branch  out  1  instruction is a conditional branch
mem_read, mem_write  out  1  data memory strobes
mem_to_reg  out  1  writeback source is memory
reg_write  out  1  register file write enable
pc_en  out  1  PC update strobe
pc_src  out  1  1 = branch target (PC+imm), 0 = PC+4
halted  out  1  core halted
illegal  out  1  halt cause: illegal instruction
bus_err  out  1  halt cause: dmem timeout
retired  out  CNT_W  retired instruction count

Behaviour:
- Reset:
  - State goes to FETCH.
  - All registered fields (addresses, imm, alu_op, alu_src, branch, mem_to_reg, retired, halted, illegal, bus_err, timeout counter) clear to 0.
  - All strobes are 0 while reset is high.
  - imem_req rises the first cycle after reset falls.
  - Reset in any state, including mid-MEMORY, aborts the instruction with no strobes.
- alu_op encoding: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLTU 0111, SLT 1000, XOR 1001, EQ 1010, NE 1011.
- States:
  - FETCH: imem_req=1. On instr_valid, latch IR and go to DECODE. Otherwise wait.
  - DECODE: register fields, imm, alu_op, alu_src, branch and mem_to_reg; these hold until the next DECODE.
    - Supported: R-type 0110011 (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU); I-ALU 0010011 (ADDI/ANDI/ORI/XORI/SLTI/SLTIU/SLLI/SRLI/SRAI, 6-bit shamt); LD (0000011, f3=011); SD (0100011, f3=011); branches 1100011 (BEQ→EQ, BNE→NE, BLT/BGE→SLT, BLTU/BGEU→SLTU).
    - Loads and stores use ADD with alu_src=1. Branches use alu_src=0.
    - Word 0x00000073 or 0x00100073 → HALT with illegal=0. Any other encoding → HALT with illegal=1.
  - EXECUTE: one cycle.
    - Branch: taken = alu_result[0], inverted for BGE/BGEU. Assert pc_en=1 and pc_src=taken, increment retired, go to FETCH.
    - LD/SD: go to MEMORY, timeout counter cleared.
    - Otherwise: go to WRITEBACK.
  - MEMORY: mem_read (LD) or mem_write (SD) held high until dmem_ready.
    - On dmem_ready: LD goes to WRITEBACK. SD asserts pc_en (pc_src=0), increments retired and goes to FETCH.
    - If the counter reaches MEM_TIMEOUT without dmem_ready: strobes drop, bus_err=1, go to HALT.
    - dmem_ready in the same cycle the counter expires counts as success.
  - WRITEBACK: reg_write=1 (suppressed when rd_addr=0), pc_en=1, pc_src=0, retired+1, go to FETCH.
  - HALT: halted=1, all strobes 0. Left only by reset.
- retired wraps modulo 2^CNT_W.
- Latency: ALU op 4 cycles; branch 3 cycles; load 5+wait cycles; store 4+wait cycles (zero-wait instr_valid/dmem_ready).

Optional Feature:
OVERFLOW_TRAP_EN
- Defined: alu_overflow=1 in EXECUTE for R-type ADD/SUB or ADDI → go to HALT, no reg_write, no retire, and sticky output ovf_trap=1 (extra port, reset 0).
- Undefined: alu_overflow is ignored and the ovf_trap port is absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants
  - funct3/funct7 constants
  - alu_op encodings
  - the FSM state enum (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT)
- Sub-module imm_gen (combinational): instr → XLEN-bit sign-extended I/S/B immediate.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3), instr_valid=1 → DECODE: alu_op=0010, alu_src=0, rd_addr=3. WRITEBACK on cycle 4: reg_write=1, pc_en=1, pc_src=0. retired=1.
2. ADDI x5,x0,-1 (0xFFF00293) → imm=0xFFFFFFFFFFFFFFFF, alu_src=1, alu_op=0010. ADDI x0 → reg_write stays 0.
3. BEQ x1,x2,+8 (0x00208463):
   - alu_result=1 → alu_op=1010, imm=8, branch=1, pc_en=1, pc_src=1 in EXECUTE.
   - alu_result=0 → pc_src=0.
   - BGE with alu_result=0 → pc_src=1.
4. LD x6,16(x1) (0x0100B303):
   - dmem_ready after 3 cycles → mem_read high 3 cycles, then reg_write=1, mem_to_reg=1.
   - dmem_ready never → bus_err=1 and halted=1 after 16 cycles.
5. instr=0xFFFFFFFF → halted=1, illegal=1, imem_req stays 0 until reset. instr=0x00000073 → halted=1, illegal=0.
6. Reset pulsed during MEMORY of SD → next cycle state FETCH, mem_write=0, retired=0. With OVERFLOW_TRAP_EN, ADD plus alu_overflow=1 → ovf_trap=1, no reg_write.
